// File: rtl/dsi_frame_sequencer_pkg.sv
// Shared definitions for the DSI video-mode frame sequencer: data types,
// state encoding, field widths and the packet-field bundle.
package dsi_frame_sequencer_pkg;

   localparam int unsigned WC_W    = 16;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned LINE_W  = 13;
   localparam int unsigned HPIX_W  = 12;
   localparam int unsigned VLINE_W = 11;
   localparam int unsigned DT_W    = 6;

   localparam logic [DT_W-1:0] DT_VSS    = 6'h01;
   localparam logic [DT_W-1:0] DT_HSS    = 6'h21;
   localparam logic [DT_W-1:0] DT_BLANK  = 6'h19;
   localparam logic [DT_W-1:0] DT_RGB888 = 6'h3E;
   localparam logic [DT_W-1:0] DT_EOTP   = 6'h08;

   localparam logic [WC_W-1:0] EOTP_CMD  = 16'h0F0F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_HBP,
      ST_ACT,
      ST_HFP,
      ST_VBL,
      ST_EOTP
   } seq_state_e;

   // Fields presented to the assembler for the packet in flight
   typedef struct packed {
      logic             islong;
      logic [DT_W-1:0]  dtype;
      logic [WC_W-1:0]  wcount;
      logic [WC_W-1:0]  command;
      logic             last;
   } pkt_fields_t;

   // RGB888 byte count for a pixel count (3 bytes per pixel, 16-bit wrap)
   function automatic logic [WC_W-1:0] pix_to_wc(input logic [WC_W-1:0] pix);
      return WC_W'(pix * WC_W'(3));
   endfunction

endpackage

// File: rtl/dsi_frame_sequencer_beat_counter.sv
// Per-packet beat counter: loaded with header+payload beat count at packet
// start, decremented on each assembler strobe; flags header and last beat.
module dsi_frame_sequencer_beat_counter
   import dsi_frame_sequencer_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] beats_i,
   input  logic             dreq_i,
   output logic             hdr_o,
   output logic             last_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hdr_q, hdr_d;
   logic             last_q, last_d;

   // Next count: load wins over decrement; flags precomputed so outputs are registered
   always_comb begin
      cnt_d  = cnt_q;
      hdr_d  = hdr_q;
      last_d = last_q;
      if (load_i) begin
         cnt_d  = beats_i;
         hdr_d  = (beats_i != '0);
         last_d = (beats_i == CNT_W'(1));
      end else if (dreq_i && (cnt_q != '0)) begin
         cnt_d  = cnt_q - CNT_W'(1);
         hdr_d  = 1'b0;
         last_d = (cnt_q == CNT_W'(2));
      end
   end

   // Counter registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q  <= '0;
         hdr_q  <= 1'b0;
         last_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         hdr_q  <= hdr_d;
         last_q <= last_d;
      end
   end

   assign hdr_o  = hdr_q;
   assign last_o = last_q;

endmodule

// File: rtl/dsi_frame_sequencer.sv
// DSI video-mode packet scheduler (sync-event mode). Walks frame/line timing
// and presents one packet at a time to the packet assembler, forwarding
// pixel data during RGB888 payload beats.
// Build option: DSI_SEQ_EOTP_EN appends an EoTp short packet at frame end
// followed by one IDLE cycle; without it HS runs continuously across frames.
module dsi_frame_sequencer
   import dsi_frame_sequencer_pkg::*;
#(
   parameter int unsigned g_pixels_per_clock = 1
) (
   input  logic                            clk_i,
   input  logic                            rst_n_i,
   input  logic                            enable_i,
   input  logic [HPIX_W-1:0]               h_bp_i,
   input  logic [HPIX_W-1:0]               h_act_i,
   input  logic [HPIX_W-1:0]               h_fp_i,
   input  logic [VLINE_W-1:0]              v_bp_i,
   input  logic [VLINE_W-1:0]              v_act_i,
   input  logic [VLINE_W-1:0]              v_fp_i,
   output logic                            p_req_o,
   output logic                            p_islong_o,
   output logic [DT_W-1:0]                 p_type_o,
   output logic [WC_W-1:0]                 p_wcount_o,
   output logic [WC_W-1:0]                 p_command_o,
   output logic [24*g_pixels_per_clock-1:0] p_payload_o,
   output logic                            p_last_o,
   input  logic                            p_dreq_i,
   input  logic [24*g_pixels_per_clock-1:0] pix_i,
   output logic                            pix_dreq_o,
   output logic                            frame_start_o,
   output logic                            busy_o
);

   localparam int unsigned PIX_W = 24 * g_pixels_per_clock;

   seq_state_e        state_q, state_d;
   logic [LINE_W-1:0] line_q, line_d;
   pkt_fields_t       fld_q, fld_d, nxt_fld_c;
   logic [CNT_W-1:0]  nxt_beats_c;
   logic              req_q, req_d;
   logic              frame_start_q, frame_start_d;

   logic [HPIX_W-1:0]  h_bp_q, h_act_q, h_fp_q;
   logic [VLINE_W-1:0] v_bp_q, v_act_q, v_fp_q;

   logic              latch_c, load_c, done_c, line_end_c;
   logic              hdr_beat, last_beat;
   logic              active_line_c;
   logic [LINE_W-1:0] act_start_c, act_end_c, last_line_c;
   logic [WC_W-1:0]   bp_pix_c, act_pix_c, fp_pix_c, tot_pix_c;

   // Header plus one payload beat per g_pixels_per_clock pixels
   function automatic logic [CNT_W-1:0] long_beats(input logic [WC_W-1:0] pix);
      return CNT_W'(pix / WC_W'(g_pixels_per_clock)) + CNT_W'(1);
   endfunction

   assign bp_pix_c  = WC_W'(h_bp_q);
   assign act_pix_c = WC_W'(h_act_q);
   assign fp_pix_c  = WC_W'(h_fp_q);
   assign tot_pix_c = bp_pix_c + act_pix_c + fp_pix_c;

   assign act_start_c   = LINE_W'(v_bp_q);
   assign act_end_c     = act_start_c + LINE_W'(v_act_q);
   assign last_line_c   = act_end_c + LINE_W'(v_fp_q) - LINE_W'(1);
   assign active_line_c = (line_q >= act_start_c) && (line_q < act_end_c);

   assign done_c = (state_q != ST_IDLE) && p_dreq_i && last_beat;
   assign load_c = done_c || ((state_q == ST_IDLE) && enable_i);

   // Next-state / line sequencing; zero-length porches are skipped
   always_comb begin
      state_d       = state_q;
      line_d        = line_q;
      latch_c       = 1'b0;
      line_end_c    = 1'b0;
      frame_start_d = done_c && (state_q == ST_SYNC) && (line_q == '0);
      case (state_q)
         ST_IDLE: begin
            if (enable_i) begin
               latch_c = 1'b1;
               state_d = ST_SYNC;
               line_d  = '0;
            end
         end
         ST_SYNC: begin
            if (done_c) begin
               if (active_line_c) begin
                  if (bp_pix_c != '0)       state_d = ST_HBP;
                  else if (act_pix_c != '0) state_d = ST_ACT;
                  else if (fp_pix_c != '0)  state_d = ST_HFP;
                  else                      line_end_c = 1'b1;
               end else if (tot_pix_c != '0) begin
                  state_d = ST_VBL;
               end else begin
                  line_end_c = 1'b1;
               end
            end
         end
         ST_HBP: begin
            if (done_c) begin
               if (act_pix_c != '0)     state_d = ST_ACT;
               else if (fp_pix_c != '0) state_d = ST_HFP;
               else                     line_end_c = 1'b1;
            end
         end
         ST_ACT: begin
            if (done_c) begin
               if (fp_pix_c != '0) state_d = ST_HFP;
               else                line_end_c = 1'b1;
            end
         end
         ST_HFP, ST_VBL: begin
            if (done_c) line_end_c = 1'b1;
         end
         ST_EOTP: begin
            if (done_c) begin
               state_d = ST_IDLE;
               line_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            line_d  = '0;
         end
      endcase

      if (line_end_c) begin
         if (line_q == last_line_c) begin
`ifdef DSI_SEQ_EOTP_EN
            state_d = ST_EOTP;
`else
            line_d = '0;
            if (enable_i) begin
               latch_c = 1'b1;
               state_d = ST_SYNC;
            end else begin
               state_d = ST_IDLE;
            end
`endif
         end else begin
            line_d  = line_q + LINE_W'(1);
            state_d = ST_SYNC;
         end
      end
   end

   // Packet fields and beat count for the packet about to start
   always_comb begin
      nxt_fld_c   = '0;
      nxt_beats_c = '0;
      case (state_d)
         ST_SYNC: begin
            nxt_fld_c.dtype = (line_d == '0) ? DT_VSS : DT_HSS;
            nxt_beats_c     = CNT_W'(1);
         end
         ST_HBP: begin
            nxt_fld_c.islong = 1'b1;
            nxt_fld_c.dtype  = DT_BLANK;
            nxt_fld_c.wcount = pix_to_wc(bp_pix_c);
            nxt_beats_c      = long_beats(bp_pix_c);
         end
         ST_ACT: begin
            nxt_fld_c.islong = 1'b1;
            nxt_fld_c.dtype  = DT_RGB888;
            nxt_fld_c.wcount = pix_to_wc(act_pix_c);
            nxt_beats_c      = long_beats(act_pix_c);
         end
         ST_HFP: begin
            nxt_fld_c.islong = 1'b1;
            nxt_fld_c.dtype  = DT_BLANK;
            nxt_fld_c.wcount = pix_to_wc(fp_pix_c);
            nxt_beats_c      = long_beats(fp_pix_c);
         end
         ST_VBL: begin
            nxt_fld_c.islong = 1'b1;
            nxt_fld_c.dtype  = DT_BLANK;
            nxt_fld_c.wcount = pix_to_wc(tot_pix_c);
            nxt_beats_c      = long_beats(tot_pix_c);
         end
         ST_EOTP: begin
            nxt_fld_c.dtype   = DT_EOTP;
            nxt_fld_c.command = EOTP_CMD;
            nxt_fld_c.last    = 1'b1;
            nxt_beats_c       = CNT_W'(1);
         end
         default: begin
            nxt_fld_c   = '0;
            nxt_beats_c = '0;
         end
      endcase
   end

   // Fields only change at packet boundaries so they stay stable across beats
   always_comb begin
      fld_d = fld_q;
      req_d = req_q;
      if (load_c) begin
         fld_d = nxt_fld_c;
         req_d = (state_d != ST_IDLE);
      end
   end

   // State, line and output registers
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q       <= ST_IDLE;
         line_q        <= '0;
         fld_q         <= '0;
         req_q         <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         line_q        <= line_d;
         fld_q         <= fld_d;
         req_q         <= req_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Timing shadows: captured only at frame start so mid-frame edits are ignored
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         h_bp_q  <= '0;
         h_act_q <= '0;
         h_fp_q  <= '0;
         v_bp_q  <= '0;
         v_act_q <= '0;
         v_fp_q  <= '0;
      end else if (latch_c) begin
         h_bp_q  <= h_bp_i;
         h_act_q <= h_act_i;
         h_fp_q  <= h_fp_i;
         v_bp_q  <= v_bp_i;
         v_act_q <= v_act_i;
         v_fp_q  <= v_fp_i;
      end
   end

   dsi_frame_sequencer_beat_counter u_beat_counter (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load_i  (load_c),
      .beats_i (nxt_beats_c),
      .dreq_i  (p_dreq_i && (state_q != ST_IDLE)),
      .hdr_o   (hdr_beat),
      .last_o  (last_beat)
   );

   assign p_req_o       = req_q;
   assign busy_o        = req_q;
   assign p_islong_o    = fld_q.islong;
   assign p_type_o      = fld_q.dtype;
   assign p_wcount_o    = fld_q.wcount;
   assign p_command_o   = fld_q.command;
   assign p_last_o      = fld_q.last;
   assign frame_start_o = frame_start_q;

   // Pixel pop and payload pass-through track the assembler strobe within the beat
   assign pix_dreq_o  = (state_q == ST_ACT) && !hdr_beat && p_dreq_i;
   assign p_payload_o = ((state_q == ST_ACT) && !hdr_beat) ? pix_i : PIX_W'(0);

endmodule

// File: tb/tb_dsi_frame_sequencer.sv
// Directed bench for dsi_frame_sequencer (PPC=1): records every completed
// packet and compares the sequence against hand-built expected lists.
module tb_dsi_frame_sequencer;

   typedef struct packed {
      logic        islong;
      logic [5:0]  typ;
      logic [15:0] wc;
      logic [15:0] cmd;
      logic        last;
   } pkt_t;

   logic        clk_i;
   logic        rst_n_i;
   logic        enable_i;
   logic [11:0] h_bp_i, h_act_i, h_fp_i;
   logic [10:0] v_bp_i, v_act_i, v_fp_i;
   logic        p_req_o, p_islong_o, p_last_o;
   logic [5:0]  p_type_o;
   logic [15:0] p_wcount_o, p_command_o;
   logic [23:0] p_payload_o, pix_i;
   logic        p_dreq_i, pix_dreq_o, frame_start_o, busy_o;

   int   total, bad;
   int   duty;
   bit   in_pkt;
   int   beat_idx, beats_need;
   pkt_t cur;
   pkt_t got_q[$];
   pkt_t exp_q[$];
   int   pops, unstable, payload_bad, pix_bad, fs_cnt;

   dsi_frame_sequencer #(.g_pixels_per_clock(1)) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .enable_i      (enable_i),
      .h_bp_i        (h_bp_i),
      .h_act_i       (h_act_i),
      .h_fp_i        (h_fp_i),
      .v_bp_i        (v_bp_i),
      .v_act_i       (v_act_i),
      .v_fp_i        (v_fp_i),
      .p_req_o       (p_req_o),
      .p_islong_o    (p_islong_o),
      .p_type_o      (p_type_o),
      .p_wcount_o    (p_wcount_o),
      .p_command_o   (p_command_o),
      .p_payload_o   (p_payload_o),
      .p_last_o      (p_last_o),
      .p_dreq_i      (p_dreq_i),
      .pix_i         (pix_i),
      .pix_dreq_o    (pix_dreq_o),
      .frame_start_o (frame_start_o),
      .busy_o        (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic pkt_t mk(input logic il, input logic [5:0] t, input logic [15:0] wc,
                               input logic [15:0] cmd, input logic last);
      pkt_t p;
      p.islong = il; p.typ = t; p.wc = wc; p.cmd = cmd; p.last = last;
      return p;
   endfunction

   task automatic set_cfg(input int hbp, input int hact, input int hfp,
                          input int vbp, input int vact, input int vfp);
      h_bp_i = 12'(hbp); h_act_i = 12'(hact); h_fp_i = 12'(hfp);
      v_bp_i = 11'(vbp); v_act_i = 11'(vact); v_fp_i = 11'(vfp);
   endtask

   task automatic clear_stats();
      got_q.delete();
      in_pkt = 0; beat_idx = 0; beats_need = 0;
      pops = 0; unstable = 0; payload_bad = 0; pix_bad = 0; fs_cnt = 0;
   endtask

   // Expected packets for h=4/8/fp, v=1/2/1 (fp is 4 or 0), nframes frames
   task automatic build_exp(input bit zero_fp, input int nframes);
      exp_q.delete();
      for (int f = 0; f < nframes; f++) begin
         exp_q.push_back(mk(1'b0, 6'h01, 16'd0, 16'd0, 1'b0));
         exp_q.push_back(mk(1'b1, 6'h19, zero_fp ? 16'd36 : 16'd48, 16'd0, 1'b0));
         for (int l = 0; l < 2; l++) begin
            exp_q.push_back(mk(1'b0, 6'h21, 16'd0, 16'd0, 1'b0));
            exp_q.push_back(mk(1'b1, 6'h19, 16'd12, 16'd0, 1'b0));
            exp_q.push_back(mk(1'b1, 6'h3E, 16'd24, 16'd0, 1'b0));
            if (!zero_fp) exp_q.push_back(mk(1'b1, 6'h19, 16'd12, 16'd0, 1'b0));
         end
         exp_q.push_back(mk(1'b0, 6'h21, 16'd0, 16'd0, 1'b0));
         exp_q.push_back(mk(1'b1, 6'h19, zero_fp ? 16'd36 : 16'd48, 16'd0, 1'b0));
`ifdef DSI_SEQ_EOTP_EN
         exp_q.push_back(mk(1'b0, 6'h08, 16'd0, 16'h0F0F, 1'b1));
`endif
      end
   endtask

   // One cycle: drive strobe/pixels at negedge, observe the beat about to be consumed
   task automatic step();
      pkt_t live;
      bit   exp_pd;
      @(negedge clk_i);
      p_dreq_i = ($urandom_range(0, 99) < duty);
      pix_i    = 24'($urandom);
      #1;
      if (frame_start_o) fs_cnt++;
      live = mk(p_islong_o, p_type_o, p_wcount_o, p_command_o, p_last_o);
      if (p_req_o) begin
         if (!in_pkt) begin
            cur        = live;
            in_pkt     = 1;
            beat_idx   = 0;
            beats_need = p_islong_o ? 1 + int'(p_wcount_o) / 3 : 1;
         end else if (live !== cur) begin
            unstable++;
         end
         if (p_dreq_i) begin
            exp_pd = cur.islong && (cur.typ == 6'h3E) && (beat_idx != 0);
            if (pix_dreq_o !== exp_pd) pix_bad++;
            if (pix_dreq_o) pops++;
            if (cur.islong && beat_idx != 0 &&
                p_payload_o !== ((cur.typ == 6'h3E) ? pix_i : 24'h0)) payload_bad++;
            beat_idx++;
            if (beat_idx == beats_need) begin
               got_q.push_back(cur);
               in_pkt = 0;
            end
         end else if (pix_dreq_o !== 1'b0) begin
            pix_bad++;
         end
      end else begin
         in_pkt = 0;
         if (pix_dreq_o !== 1'b0) pix_bad++;
      end
   endtask

   // Run until the sequencer returns to idle; enable dropped after drop_at cycles
   task automatic run_frame(input int budget, input int drop_at, output bit ok);
      bit seen = 0;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (i == drop_at) enable_i = 1'b0;
         if (p_req_o) seen = 1;
         if (seen && !busy_o) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0; enable_i = 1'b0; p_dreq_i = 1'b1; pix_i = 24'hABCDEF;
      set_cfg(4, 8, 4, 1, 2, 1);
      repeat (3) @(negedge clk_i);
      #1;
      total++; if (p_req_o !== 1'b0)     begin bad++; $display("FAIL rst_req got=%0b want=0", p_req_o); end
      total++; if (busy_o !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%0b want=0", busy_o); end
      total++; if (p_islong_o !== 1'b0)  begin bad++; $display("FAIL rst_islong got=%0b want=0", p_islong_o); end
      total++; if (p_type_o !== 6'h00)   begin bad++; $display("FAIL rst_type got=%h want=00", p_type_o); end
      total++; if (p_wcount_o !== 16'h0) begin bad++; $display("FAIL rst_wc got=%h want=0", p_wcount_o); end
      total++; if (p_command_o !== 16'h0) begin bad++; $display("FAIL rst_cmd got=%h want=0", p_command_o); end
      total++; if (p_payload_o !== 24'h0) begin bad++; $display("FAIL rst_payload got=%h want=0", p_payload_o); end
      total++; if (p_last_o !== 1'b0)    begin bad++; $display("FAIL rst_last got=%0b want=0", p_last_o); end
      total++; if (pix_dreq_o !== 1'b0)  begin bad++; $display("FAIL rst_pixdreq got=%0b want=0", pix_dreq_o); end
      total++; if (frame_start_o !== 1'b0) begin bad++; $display("FAIL rst_fs got=%0b want=0", frame_start_o); end
      rst_n_i = 1'b1; p_dreq_i = 1'b0;
      @(negedge clk_i); #1;
      total++; if (p_req_o !== 1'b0) begin bad++; $display("FAIL idle_req got=%0b want=0", p_req_o); end
   endtask

   task automatic test_basic_frame();
      bit ok; pkt_t g;
      clear_stats(); duty = 100; set_cfg(4, 8, 4, 1, 2, 1); build_exp(1'b0, 1);
      enable_i = 1'b1;
      run_frame(2000, 0, ok);
      total++; if (!ok) begin bad++; $display("FAIL t1_timeout got=busy want=idle"); end
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL t1_npkt got=%0d want=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         g = (i < got_q.size()) ? got_q[i] : '0;
         total++; if (g !== exp_q[i]) begin bad++; $display("FAIL t1_pkt%0d got=%h want=%h", i, g, exp_q[i]); end
      end
      total++; if (pops != 16)      begin bad++; $display("FAIL t1_pops got=%0d want=16", pops); end
      total++; if (fs_cnt != 1)     begin bad++; $display("FAIL t1_fs got=%0d want=1", fs_cnt); end
      total++; if (pix_bad != 0)    begin bad++; $display("FAIL t1_pixdreq got=%0d want=0", pix_bad); end
      total++; if (payload_bad != 0) begin bad++; $display("FAIL t1_payload got=%0d want=0", payload_bad); end
   endtask

   task automatic test_backpressure();
      bit ok; pkt_t g;
      clear_stats(); duty = 30; set_cfg(4, 8, 4, 1, 2, 1); build_exp(1'b0, 1);
      enable_i = 1'b1;
      run_frame(5000, 0, ok);
      total++; if (!ok) begin bad++; $display("FAIL t2_timeout got=busy want=idle"); end
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL t2_npkt got=%0d want=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         g = (i < got_q.size()) ? got_q[i] : '0;
         total++; if (g !== exp_q[i]) begin bad++; $display("FAIL t2_pkt%0d got=%h want=%h", i, g, exp_q[i]); end
      end
      total++; if (pops != 16)       begin bad++; $display("FAIL t2_pops got=%0d want=16", pops); end
      total++; if (unstable != 0)    begin bad++; $display("FAIL t2_stable got=%0d want=0", unstable); end
      total++; if (pix_bad != 0)     begin bad++; $display("FAIL t2_pixdreq got=%0d want=0", pix_bad); end
      total++; if (payload_bad != 0) begin bad++; $display("FAIL t2_payload got=%0d want=0", payload_bad); end
   endtask

   task automatic test_zero_front_porch();
      bit ok; pkt_t g;
      clear_stats(); duty = 100; set_cfg(4, 8, 0, 1, 2, 1); build_exp(1'b1, 1);
      enable_i = 1'b1;
      run_frame(2000, 0, ok);
      total++; if (!ok) begin bad++; $display("FAIL t3_timeout got=busy want=idle"); end
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL t3_npkt got=%0d want=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         g = (i < got_q.size()) ? got_q[i] : '0;
         total++; if (g !== exp_q[i]) begin bad++; $display("FAIL t3_pkt%0d got=%h want=%h", i, g, exp_q[i]); end
      end
      total++; if (pops != 16) begin bad++; $display("FAIL t3_pops got=%0d want=16", pops); end
   endtask

   task automatic test_enable_drop();
      bit ok; pkt_t g;
      clear_stats(); duty = 100; set_cfg(4, 8, 4, 1, 2, 1); build_exp(1'b0, 1);
      enable_i = 1'b1;
      step(); step();
      set_cfg(2, 6, 3, 3, 3, 3);
      run_frame(2000, 13, ok);
      total++; if (!ok) begin bad++; $display("FAIL t4_timeout got=busy want=idle"); end
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL t4_npkt got=%0d want=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         g = (i < got_q.size()) ? got_q[i] : '0;
         total++; if (g !== exp_q[i]) begin bad++; $display("FAIL t4_pkt%0d got=%h want=%h", i, g, exp_q[i]); end
      end
      total++; if (fs_cnt != 1) begin bad++; $display("FAIL t4_fs got=%0d want=1", fs_cnt); end
      step(); step();
      total++; if (p_req_o !== 1'b0) begin bad++; $display("FAIL t4_stay_idle got=%0b want=0", p_req_o); end
   endtask

   task automatic test_reset_mid_payload();
      bit found = 0;
      clear_stats(); duty = 100; set_cfg(4, 8, 4, 1, 2, 1);
      enable_i = 1'b1;
      for (int i = 0; i < 300; i++) begin
         step();
         if (i == 0) enable_i = 1'b0;
         if (in_pkt && cur.typ == 6'h3E && beat_idx >= 2) begin
            found = 1;
            break;
         end
      end
      total++; if (!found) begin bad++; $display("FAIL t5_no_act got=0 want=1"); end
      total++; if (pix_dreq_o !== 1'b1) begin bad++; $display("FAIL t5_pre_pop got=%0b want=1", pix_dreq_o); end
      rst_n_i = 1'b0;
      @(negedge clk_i); #1;
      total++; if (p_req_o !== 1'b0)    begin bad++; $display("FAIL t5_req got=%0b want=0", p_req_o); end
      total++; if (busy_o !== 1'b0)     begin bad++; $display("FAIL t5_busy got=%0b want=0", busy_o); end
      total++; if (pix_dreq_o !== 1'b0) begin bad++; $display("FAIL t5_pixdreq got=%0b want=0", pix_dreq_o); end
      rst_n_i = 1'b1; p_dreq_i = 1'b0; in_pkt = 0;
      @(negedge clk_i);
   endtask

   task automatic test_back_to_back();
      bit ok; pkt_t g;
      clear_stats(); duty = 100; set_cfg(4, 8, 4, 1, 2, 1); build_exp(1'b0, 2);
      enable_i = 1'b1;
      run_frame(2000, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL t6_timeout got=busy want=idle"); end
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL t6_npkt got=%0d want=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         g = (i < got_q.size()) ? got_q[i] : '0;
         total++; if (g !== exp_q[i]) begin bad++; $display("FAIL t6_pkt%0d got=%h want=%h", i, g, exp_q[i]); end
      end
      total++; if (fs_cnt != 2) begin bad++; $display("FAIL t6_fs got=%0d want=2", fs_cnt); end
      total++; if (pops != 32)  begin bad++; $display("FAIL t6_pops got=%0d want=32", pops); end
   endtask

   initial begin
      total = 0; bad = 0; duty = 0;
      clear_stats();
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_zero_front_porch();
      test_enable_drop();
      test_reset_mid_payload();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
